// File: rtl/fifo_read_ctrl_pkg.sv
// Shared constants for the FIFO read-side drain engine.
// Latency: none (definitions only).
// Backpressure: not applicable.
package fifo_read_ctrl_pkg;

    // FSM encoding, kept as plain constants so older tools and waveform scripts can decode it
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Skid buffer depth and the width needed to count 0..SKID_DEPTH entries
    localparam int SKID_DEPTH    = 2;
    localparam int OCC_W         = $clog2(SKID_DEPTH + 1);

    // Default width of burst length and delivered-word counter
    localparam int DEF_CNT_WIDTH = 8;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer between the FIFO read port and the downstream consumer.
// Latency: a pushed word is visible at the head on the cycle after the push.
// Backpressure: head is held while not popped; caller must not push when full without a pop.
module fifo_rd_skid
    import fifo_read_ctrl_pkg::*;
#(
    parameter int data_width = 4
) (
    input  logic                  rd_clk,
    input  logic                  rd_reset_n,
    input  logic                  push,
    input  logic [data_width-1:0] push_dat,
    input  logic                  pop,
    output logic [OCC_W-1:0]      occ,
    output logic [data_width-1:0] head_dat
);

    logic [data_width-1:0] ent0;
    logic [data_width-1:0] ent1;

    assign head_dat = ent0;

    // ent0 is always the head; entries shift forward on pop so order is preserved
    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            occ  <= '0;
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == '0) ent0 <= push_dat;
                    else           ent1 <= push_dat;
                    occ <= occ + OCC_W'(1);
                end
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - OCC_W'(1);
                end
                2'b11: begin
                    // occupancy unchanged; new word lands behind whatever remains
                    if (occ == OCC_W'(1)) begin
                        ent0 <= push_dat;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Drains burst_len words from the async FIFO read port into a valid/ready stream.
// Latency: start->first rd_en 1 cycle, rd_en->m_valid 2 cycles, last transfer->done 1 cycle.
// Backpressure: m_ready low holds m_data; reads stop once skid + in-flight would exceed 2.
// Optional FIFO_READ_CTRL_TIMEOUT_EN: stall counter that aborts a burst starved by an empty FIFO.
module fifo_read_ctrl
    import fifo_read_ctrl_pkg::*;
#(
    parameter int data_width     = 4,
    parameter int cnt_width      = DEF_CNT_WIDTH,
    parameter int timeout_cycles = 255
) (
    input  logic                  rd_clk,
    input  logic                  rd_reset_n,
    input  logic                  start,
    input  logic [cnt_width-1:0]  burst_len,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [data_width-1:0] fifo_data_out,
    output logic                  rd_en,
    output logic [data_width-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic [cnt_width-1:0]  words_done,
    output logic                  underflow_err,
    output logic                  timeout_err
);

    localparam logic [cnt_width-1:0] ONE = cnt_width'(1);

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [cnt_width-1:0] issue_left;
    logic                 inflight;
    logic [OCC_W-1:0]     occ;
    logic                 pop;
    logic                 room;
    logic                 force_drain;
    logic                 accept;

    assign accept  = (state == ST_IDLE) && start;
    assign m_valid = (occ != '0);
    assign pop     = m_valid && m_ready;
    assign done    = (state == ST_DONE);

    // Counting this cycle's pop keeps 1 word/cycle with m_ready high while still
    // guaranteeing the word returning next cycle finds a free skid slot.
    assign room  = ({1'b0, occ} + {2'b00, inflight}) < ({2'b00, pop} + 3'd2);
    assign rd_en = (state == ST_RUN) && !fifo_empty && (issue_left != '0) && room;

    fifo_rd_skid #(
        .data_width (data_width)
    ) u_skid (
        .rd_clk     (rd_clk),
        .rd_reset_n (rd_reset_n),
        .push       (inflight),
        .push_dat   (fifo_data_out),
        .pop        (pop),
        .occ        (occ),
        .head_dat   (m_data)
    );

`ifdef FIFO_READ_CTRL_TIMEOUT_EN
    localparam int STALL_W = $clog2(timeout_cycles + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               stall;

    assign stall       = (state == ST_RUN) && (issue_left != '0) && fifo_empty;
    assign force_drain = stall && (stall_cnt == STALL_W'(timeout_cycles - 1));

    // Stall counter counts starved RUN cycles; error is sticky until the next accepted start
    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept)           timeout_err <= 1'b0;
            else if (force_drain) timeout_err <= 1'b1;

            if (rd_en || (state != ST_RUN)) stall_cnt <= '0;
            else if (stall)                 stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (timeout_cycles != 0);
    assign force_drain    = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // Next-state decode: DRAIN ends as soon as the last word leaves the skid this cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = (burst_len == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (force_drain || (rd_en && (issue_left == ONE))) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!inflight && (occ == {1'b0, pop})) state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Burst bookkeeping: issue count, in-flight read, delivered count, sticky underflow
    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            inflight      <= 1'b0;
            issue_left    <= '0;
            words_done    <= '0;
            underflow_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
            inflight <= rd_en;
            if (accept) begin
                issue_left    <= burst_len;
                words_done    <= '0;
                underflow_err <= 1'b0;
            end else begin
                if (rd_en) issue_left <= issue_left - ONE;
                if (pop)   words_done <= words_done + ONE;
                if (fifo_underflow && ((state == ST_RUN) || (state == ST_DRAIN)))
                    underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl with a behavioural FIFO model on the read port.
// Latency: expected words are queued at FIFO write time and matched on each downstream transfer.
// Backpressure: m_ready is driven by the bench; held data and outstanding reads are checked each cycle.
module tb_fifo_read_ctrl;

    localparam int DW = 4;
    localparam int CW = 8;
    localparam int TO = 20;

    logic          rd_clk         = 1'b0;
    logic          rd_reset_n     = 1'b0;
    logic          start          = 1'b0;
    logic [CW-1:0] burst_len      = '0;
    logic          fifo_empty     = 1'b1;
    logic          fifo_underflow = 1'b0;
    logic [DW-1:0] fifo_data_out  = '0;
    logic          rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready        = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] words_done;
    logic          underflow_err;
    logic          timeout_err;

    always #5 rd_clk = ~rd_clk;

    fifo_read_ctrl #(
        .data_width     (DW),
        .cnt_width      (CW),
        .timeout_cycles (TO)
    ) dut (
        .rd_clk         (rd_clk),
        .rd_reset_n     (rd_reset_n),
        .start          (start),
        .burst_len      (burst_len),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .rd_en          (rd_en),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .busy           (busy),
        .done           (done),
        .words_done     (words_done),
        .underflow_err  (underflow_err),
        .timeout_err    (timeout_err)
    );

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic          wr_req   = 1'b0;
    logic [DW-1:0] wr_dat   = '0;
    int            cyc      = 0;
    int            rd_cnt   = 0;
    int            xf_cnt   = 0;
    int            first_rd_cyc = -1;
    int            first_xf_cyc = -1;
    int            last_xf_cyc  = -1;
    logic          hold_vld = 1'b0;
    logic [DW-1:0] hold_dat = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO model: one-cycle read latency, writes land at the clock edge
    always @(posedge rd_clk) begin
        logic [DW-1:0] w;
        cyc++;
        if (rd_en && fifo_q.size() != 0) begin
            w = fifo_q.pop_front();
            fifo_data_out <= w;
        end
        if (wr_req) fifo_q.push_back(wr_dat);
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Monitor: scoreboard compare on transfer, hold stability, no read while empty, outstanding bound
    always @(negedge rd_clk) begin
        logic [DW-1:0] e;
        if (!rd_reset_n) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, hold_dat);
            end
            if (rd_en) begin
                chk("rd_while_empty", fifo_empty, 0);
                rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (m_valid && m_ready) begin
                chk("sb_has_entry", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e);
                end
                xf_cnt++;
                if (first_xf_cyc < 0) first_xf_cyc = cyc;
                last_xf_cyc = cyc;
            end
            if (rd_en) chk("outstanding_le2", (rd_cnt - xf_cnt) <= 2, 1);
            hold_vld = m_valid && !m_ready;
            hold_dat = m_data;
        end
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic do_reset();
        rd_reset_n     = 1'b0;
        start          = 1'b0;
        m_ready        = 1'b0;
        wr_req         = 1'b0;
        fifo_underflow = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        rd_cnt = 0;
        xf_cnt = 0;
        first_rd_cyc = -1;
        first_xf_cyc = -1;
        last_xf_cyc  = -1;
        repeat (3) tick();
        rd_reset_n = 1'b1;
        tick();
    endtask

    task automatic wr_word(input logic [DW-1:0] w);
        wr_req = 1'b1;
        wr_dat = w;
        exp_q.push_back(w);
        tick();
        wr_req = 1'b0;
    endtask

    task automatic start_burst(input int n);
        start     = 1'b1;
        burst_len = CW'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                dcyc = cyc;
                break;
            end
            tick();
        end
        chk(tag, done, 1);
    endtask

    initial begin
        int dc;
        int ok;

        // reset state
        do_reset();
        chk("rst_rd_en", rd_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_words", words_done, 0);
        chk("rst_uflow", underflow_err, 0);
        chk("rst_tmo", timeout_err, 0);

        // basic burst
        m_ready = 1'b1;
        wr_word(4'h5); wr_word(4'hA); wr_word(4'h3); wr_word(4'hC);
        tick();
        start_burst(4);
        chk("t1_first_rd", rd_en, 1);
        chk("t1_busy", busy, 1);
        wait_done("t1_done", 30, dc);
        chk("t1_rd_cnt", rd_cnt, 4);
        chk("t1_words", words_done, 4);
        chk("t1_uflow", underflow_err, 0);
        chk("t1_busy_done", busy, 0);
        chk("t1_rd_to_valid", first_xf_cyc - first_rd_cyc, 2);
        chk("t1_back_to_back", last_xf_cyc - first_xf_cyc, 3);
        chk("t1_done_lat", dc - last_xf_cyc, 1);
        chk("t1_sb_empty", exp_q.size(), 0);
        tick();
        chk("t1_done_pulse", done, 0);

        // backpressure
        do_reset();
        wr_word(4'h5); wr_word(4'hA); wr_word(4'h3); wr_word(4'hC);
        tick();
        start_burst(4);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_valid) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk("t2_valid_seen", ok, 1);
        repeat (6) tick();
        chk("t2_head_held", m_data, 4'h5);
        chk("t2_rd_limit", rd_cnt, 2);
        m_ready = 1'b1;
        wait_done("t2_done", 30, dc);
        chk("t2_words", words_done, 4);
        chk("t2_sb_empty", exp_q.size(), 0);

        // empty FIFO stall
        do_reset();
        m_ready = 1'b1;
        start_burst(3);
        repeat (10) tick();
        chk("t3_no_rd", rd_cnt, 0);
        chk("t3_busy", busy, 1);
        chk("t3_tmo_clear", timeout_err, 0);
        wr_word(4'h7); wr_word(4'h1); wr_word(4'hE);
        wait_done("t3_done", 30, dc);
        chk("t3_words", words_done, 3);
        chk("t3_sb_empty", exp_q.size(), 0);

        // zero length, then start ignored mid-burst
        do_reset();
        m_ready = 1'b1;
        start_burst(0);
        chk("t4_zero_done", done, 1);
        chk("t4_zero_busy", busy, 0);
        chk("t4_zero_rd", rd_cnt, 0);
        tick();
        chk("t4_zero_pulse", done, 0);
        wr_word(4'h9); wr_word(4'h6);
        tick();
        start_burst(2);
        start_burst(5);
        wait_done("t4_done", 30, dc);
        chk("t4_words", words_done, 2);
        repeat (4) tick();
        chk("t4_idle_busy", busy, 0);
        chk("t4_rd_cnt", rd_cnt, 2);

        // reset mid-burst
        do_reset();
        m_ready = 1'b1;
        wr_word(4'h1); wr_word(4'h2); wr_word(4'h3); wr_word(4'h4);
        tick();
        start_burst(4);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (xf_cnt >= 2) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk("t5_two_words", ok, 1);
        chk("t5_words_pre", words_done, 2);
        rd_reset_n = 1'b0;
        #1;
        chk("t5_rd_en", rd_en, 0);
        chk("t5_m_valid", m_valid, 0);
        chk("t5_m_data", m_data, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_words", words_done, 0);
        chk("t5_uflow", underflow_err, 0);
        chk("t5_tmo", timeout_err, 0);
        do_reset();
        m_ready = 1'b1;
        wr_word(4'hB); wr_word(4'hD); wr_word(4'hF); wr_word(4'h8);
        tick();
        start_burst(4);
        chk("t5_first_rd", rd_en, 1);
        wait_done("t5_done_after", 30, dc);
        chk("t5_words_after", words_done, 4);
        chk("t5_sb_empty", exp_q.size(), 0);

        // underflow flag: ignored in IDLE, sticky during burst, cleared by next start
        do_reset();
        m_ready = 1'b1;
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        chk("t6_idle_uflow", underflow_err, 0);
        wr_word(4'h5); wr_word(4'h9);
        tick();
        start_burst(2);
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        wait_done("t6_done", 30, dc);
        chk("t6_uflow", underflow_err, 1);
        chk("t6_words", words_done, 2);
        tick();
        chk("t6_sticky", underflow_err, 1);
        start_burst(0);
        chk("t6_cleared", underflow_err, 0);

`ifdef FIFO_READ_CTRL_TIMEOUT_EN
        // starved burst aborts after the stall limit
        do_reset();
        m_ready = 1'b1;
        wr_word(4'h3); wr_word(4'h6);
        tick();
        start_burst(4);
        wait_done("t7_done", 200, dc);
        chk("t7_tmo", timeout_err, 1);
        chk("t7_words", words_done, 2);
        chk("t7_rd_cnt", rd_cnt, 2);
        chk("t7_sb_empty", exp_q.size(), 0);
        tick();
        chk("t7_done_pulse", done, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule
